// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter_pkg: shared definitions for the two-source mux arbiter.
//   state_t : FSM encodings (IDLE=00, G0=01, G1=10; 11 unused, recovers to IDLE)
//   SEL_X / SEL_Y : mux select values for source 0 (x) and source 1 (y)
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

endpackage

// File: rtl/mux2_arbiter_if.sv
// mux2_arbiter_if: request/grant bundle between the two sources and the arbiter.
//   req      : level requests, bit 0 = source 0 (mux x), bit 1 = source 1 (mux y)
//   grant    : one-hot grant, 00 when idle
//   sel      : mux select (0 = x, 1 = y)
//   valid    : mux output owned this cycle
//   hold_cnt : consecutive contended-cycle count of the current owner
// master = requester side, slave = arbiter side.
interface mux2_arbiter_if #(
    parameter int CW = 4
);
    logic [1:0]    req;
    logic [1:0]    grant;
    logic          sel;
    logic          valid;
    logic [CW-1:0] hold_cnt;

    modport master (output req, input grant, sel, valid, hold_cnt);
    modport slave  (input req, output grant, sel, valid, hold_cnt);
endinterface

// File: rtl/mux2_arbiter_hold_counter.sv
// hold_counter: CW-bit up counter with synchronous clear and enable.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clr          : clear to 0 (wins over en)
//   en           : increment
//   cnt          : current count
//   term         : cnt == MAX_HOLD-1, i.e. the owner is on its last allowed cycle
module hold_counter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          term
);

    always_ff @(posedge clock) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign term = (cnt == CW'(MAX_HOLD - 1));

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin arbiter driving the select of a shared 2-to-1 mux.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : req in; grant, sel, valid, hold_cnt out (all registered)
// An owner under continuous contention keeps the grant for MAX_HOLD cycles,
// then it passes to the waiting source. Without contention a grant is kept
// indefinitely.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic          clock,
    input  logic          reset,
    mux2_arbiter_if.slave bus
);

    state_t        state, nxt;
    logic          last;     // index of the most recent owner; loser of the next tie
    logic          clr, en, term;
    logic [CW-1:0] cnt;

    hold_counter #(.MAX_HOLD(MAX_HOLD), .CW(CW)) u_hold (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .cnt   (cnt),
        .term  (term)
    );

    // Counter only advances while the owner stays and the other side waits;
    // every other path (state change, no contention) clears it.
    always_comb begin
        nxt = IDLE;
        clr = 1'b1;
        en  = 1'b0;
        case (state)
            IDLE: begin
                case (bus.req)
                    2'b01:   nxt = G0;
                    2'b10:   nxt = G1;
                    2'b11:   nxt = last ? G0 : G1;
                    default: nxt = IDLE;
                endcase
            end
            G0: begin
                if (!bus.req[0])
                    nxt = bus.req[1] ? G1 : IDLE;
                else if (bus.req[1] && !term) begin
                    nxt = G0;
                    clr = 1'b0;
                    en  = 1'b1;
                end else if (bus.req[1])
                    nxt = G1;
                else
                    nxt = G0;
            end
            G1: begin
                if (!bus.req[1])
                    nxt = bus.req[0] ? G0 : IDLE;
                else if (bus.req[0] && !term) begin
                    nxt = G1;
                    clr = 1'b0;
                    en  = 1'b1;
                end else if (bus.req[0])
                    nxt = G0;
                else
                    nxt = G1;
            end
            default: nxt = IDLE;   // unused encoding recovers
        endcase
    end

    // Outputs are decoded from nxt into registers so they line up with state
    // and have no combinational path from req. sel holds while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            bus.grant <= 2'b00;
            bus.sel   <= SEL_X;
            bus.valid <= 1'b0;
        end else begin
            state <= nxt;
            case (nxt)
                G0: begin
                    bus.grant <= 2'b01;
                    bus.sel   <= SEL_X;
                    bus.valid <= 1'b1;
                    last      <= 1'b0;
                end
                G1: begin
                    bus.grant <= 2'b10;
                    bus.sel   <= SEL_Y;
                    bus.valid <= 1'b1;
                    last      <= 1'b1;
                end
                default: begin
                    bus.grant <= 2'b00;
                    bus.valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hold_cnt = cnt;

endmodule
